// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the single-bus CPU control path: opcode values,
//   the sequencer state encoding and the packed control word that the step
//   decoder produces and the sequencer drives onto its output ports.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int OPC_W = 5;

    // Opcodes, IR[31:27]
    localparam logic [OPC_W-1:0] OP_LD        = 5'd0;
    localparam logic [OPC_W-1:0] OP_LDI       = 5'd1;
    localparam logic [OPC_W-1:0] OP_ST        = 5'd2;
    localparam logic [OPC_W-1:0] OP_ALU_FIRST = 5'd3;   // register ALU ops 3..10
    localparam logic [OPC_W-1:0] OP_ALU_LAST  = 5'd10;
    localparam logic [OPC_W-1:0] OP_IMM_FIRST = 5'd11;  // immediate ALU ops 11..13
    localparam logic [OPC_W-1:0] OP_IMM_LAST  = 5'd13;
    localparam logic [OPC_W-1:0] OP_MUL       = 5'd14;
    localparam logic [OPC_W-1:0] OP_DIV       = 5'd15;
    localparam logic [OPC_W-1:0] OP_BRX       = 5'd18;
    localparam logic [OPC_W-1:0] OP_HALT      = 5'd27;

    localparam logic [OPC_W-1:0] ALU_ADD      = 5'd3;

    typedef enum logic [3:0] {
        S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT, S_FAULT
    } state_e;

    typedef struct packed {
        logic             pc_out;
        logic             zlow_out;
        logic             zhigh_out;
        logic             mdr_out;
        logic             c_out;
        logic             r_out;
        logic             mar_en;
        logic             mdr_en;
        logic             ir_en;
        logic             y_en;
        logic             z_en;
        logic             pc_en;
        logic             hi_en;
        logic             lo_en;
        logic             con_en;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             r_in;
        logic             ba_out;
        logic             inc_pc;
        logic             read;
        logic             write;
        logic [OPC_W-1:0] alu_op;
        logic             run;
        logic             fault;
    } ctrl_t;

    function automatic logic is_alu_reg(input logic [OPC_W-1:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

    function automatic logic is_alu_imm(input logic [OPC_W-1:0] op);
        return (op >= OP_IMM_FIRST) && (op <= OP_IMM_LAST);
    endfunction

    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return op <= OP_ST;
    endfunction

    function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_step_decode.sv
// ----------------------------------------------------------------------------
// seq_step_decode
//   Purely combinational control-word decode for the step sequencer.
//   Ports:
//     state_i    current sequencer step
//     opc_i      opcode latched at the end of T2
//     con_ff_i   branch condition flag (only consulted by brx in T6)
//     ctrl_o     raw control word (mdr_en not yet gated by mem_ready)
//     mem_wait_o high when the current step waits on the memory handshake
// ----------------------------------------------------------------------------
module seq_step_decode
    import cpu_pkg::*;
(
    input  state_e           state_i,
    input  logic [OPC_W-1:0] opc_i,
    input  logic             con_ff_i,
    output ctrl_t            ctrl_o,
    output logic             mem_wait_o
);

    // NOTE: every output of a combinational block gets a default first;
    // without it any path that skips an assignment infers a latch.
    always_comb begin
        ctrl_o     = '0;
        mem_wait_o = 1'b0;
        case (state_i)
            T0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_en = 1'b1;
                ctrl_o.inc_pc = 1'b1;
            end
            T1: begin
                ctrl_o.read   = 1'b1;
                ctrl_o.mdr_en = 1'b1;
                mem_wait_o    = 1'b1;
            end
            T2: begin
                ctrl_o.mdr_out = 1'b1;
                ctrl_o.ir_en   = 1'b1;
            end
            T3: begin
                if (is_alu_reg(opc_i) || is_alu_imm(opc_i)) begin
                    ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_en = 1'b1;
                end else if (is_mem_op(opc_i)) begin
                    ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_en = 1'b1;
                end else if (is_muldiv(opc_i)) begin
                    ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_en = 1'b1;
                end else if (opc_i == OP_BRX) begin
                    ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.con_en = 1'b1;
                end
            end
            T4: begin
                if (is_alu_reg(opc_i)) begin
                    ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1;
                    ctrl_o.z_en = 1'b1; ctrl_o.alu_op = opc_i;
                end else if (is_alu_imm(opc_i)) begin
                    ctrl_o.c_out = 1'b1; ctrl_o.z_en = 1'b1; ctrl_o.alu_op = opc_i;
                end else if (is_mem_op(opc_i)) begin
                    // effective address = base + displacement
                    ctrl_o.c_out = 1'b1; ctrl_o.z_en = 1'b1; ctrl_o.alu_op = ALU_ADD;
                end else if (is_muldiv(opc_i)) begin
                    ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1;
                    ctrl_o.z_en = 1'b1; ctrl_o.alu_op = opc_i;
                end else if (opc_i == OP_BRX) begin
                    ctrl_o.pc_out = 1'b1; ctrl_o.y_en = 1'b1;
                end
            end
            T5: begin
                if (is_alu_reg(opc_i) || is_alu_imm(opc_i) || opc_i == OP_LDI) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                end else if (opc_i == OP_LD || opc_i == OP_ST) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.mar_en = 1'b1;
                end else if (is_muldiv(opc_i)) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.lo_en = 1'b1;
                end else if (opc_i == OP_BRX) begin
                    ctrl_o.c_out = 1'b1; ctrl_o.z_en = 1'b1; ctrl_o.alu_op = ALU_ADD;
                end
            end
            T6: begin
                if (opc_i == OP_LD) begin
                    ctrl_o.read = 1'b1; ctrl_o.mdr_en = 1'b1; mem_wait_o = 1'b1;
                end else if (opc_i == OP_ST) begin
                    ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.mdr_en = 1'b1;
                end else if (is_muldiv(opc_i)) begin
                    ctrl_o.zhigh_out = 1'b1; ctrl_o.hi_en = 1'b1;
                end else if (opc_i == OP_BRX && con_ff_i) begin
                    // branch taken: PC <= PC + displacement
                    ctrl_o.pc_en = 1'b1; ctrl_o.zlow_out = 1'b1;
                end
            end
            T7: begin
                if (opc_i == OP_LD) begin
                    ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                end else if (opc_i == OP_ST) begin
                    ctrl_o.write = 1'b1; mem_wait_o = 1'b1;
                end
            end
            S_FAULT: ctrl_o.fault = 1'b1;
            default: ;
        endcase
        ctrl_o.run = (state_i != S_RST) && (state_i != S_HALT) && (state_i != S_FAULT);
    end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//   Hardwired step sequencer for the single-bus datapath. Holds the step
//   register, the opcode latch and (optionally) the memory wait counter;
//   seq_step_decode turns step + opcode into the control word.
//   Optional feature macro: SEQ_MEM_HANDSHAKE_EN
//     defined   : memory steps stall on mem_ready_i, timeout -> S_FAULT
//     undefined : mem_ready_i ignored, memory steps last one cycle, fault 0
//   Ports:
//     clock_i, clear_i        clock, synchronous active-high reset
//     ir_i                    instruction register (opcode = ir_i[31:27])
//     con_ff_i, mem_ready_i   branch flag, memory done strobe
//     *_out_o                 one-hot bus drive selects
//     *_en_o                  register load enables
//     gra/grb/grc/r_in/ba_out GPR select strobes
//     inc_pc/read/write       PC increment, memory request
//     alu_op_o, run_o, fault_o
// ----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic [31:0]      ir_i,
    input  logic             con_ff_i,
    input  logic             mem_ready_i,
    output logic             pc_out_o,
    output logic             zlow_out_o,
    output logic             zhigh_out_o,
    output logic             mdr_out_o,
    output logic             c_out_o,
    output logic             r_out_o,
    output logic             mar_en_o,
    output logic             mdr_en_o,
    output logic             ir_en_o,
    output logic             y_en_o,
    output logic             z_en_o,
    output logic             pc_en_o,
    output logic             hi_en_o,
    output logic             lo_en_o,
    output logic             con_en_o,
    output logic             gra_o,
    output logic             grb_o,
    output logic             grc_o,
    output logic             r_in_o,
    output logic             ba_out_o,
    output logic             inc_pc_o,
    output logic             read_o,
    output logic             write_o,
    output logic [OPC_W-1:0] alu_op_o,
    output logic             run_o,
    output logic             fault_o
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    ctrl_t            ctrl_raw, ctrl;
    logic             mem_wait;
    logic             mem_go;
    logic             timeout;
    logic             unused_ir;

    assign unused_ir = ^ir_i[31-OPC_W:0];

    seq_step_decode u_decode (
        .state_i    (state_q),
        .opc_i      (opc_q),
        .con_ff_i   (con_ff_i),
        .ctrl_o     (ctrl_raw),
        .mem_wait_o (mem_wait)
    );

`ifdef SEQ_MEM_HANDSHAKE_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign mem_go  = mem_ready_i;
    assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT));

    // Counts stalled cycles of the current wait step; any exit clears it.
    always_comb begin
        cnt_d = '0;
        if (mem_wait && !mem_go && !timeout)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // MDR loads only on the cycle the memory reports done, so a stalled
    // read captures exactly once.
    always_comb begin
        ctrl        = ctrl_raw;
        ctrl.mdr_en = ctrl_raw.mdr_en & (~mem_wait | mem_ready_i);
    end
`else
    logic [2:0] unused_cfg;

    assign mem_go     = 1'b1;
    assign timeout    = 1'b0;
    assign unused_cfg = {mem_ready_i, ctrl_raw.fault, (MEM_TIMEOUT != 0)};

    always_comb begin
        ctrl       = ctrl_raw;
        ctrl.fault = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            S_RST: state_d = T0;
            T0:    state_d = T1;
            T1:    state_d = T2;
            T2: begin
                state_d = T3;
                opc_d   = ir_i[31 -: OPC_W];
            end
            T3: begin
                if (opc_q == OP_HALT)
                    state_d = S_HALT;
                else if (is_alu_reg(opc_q) || is_alu_imm(opc_q) || is_mem_op(opc_q) ||
                         is_muldiv(opc_q) || opc_q == OP_BRX)
                    state_d = T4;
                else
                    state_d = T0;
            end
            T4: state_d = T5;
            T5: begin
                if (is_alu_reg(opc_q) || is_alu_imm(opc_q) || opc_q == OP_LDI)
                    state_d = T0;
                else
                    state_d = T6;
            end
            T6:      state_d = (opc_q == OP_LD || opc_q == OP_ST) ? T7 : T0;
            T7:      state_d = T0;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_RST;
        endcase

        // A wait step holds until memory is done; a ready on the timeout
        // cycle still advances normally.
        if (mem_wait && !mem_go)
            state_d = timeout ? S_FAULT : state_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q <= S_RST;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    assign pc_out_o    = ctrl.pc_out;
    assign zlow_out_o  = ctrl.zlow_out;
    assign zhigh_out_o = ctrl.zhigh_out;
    assign mdr_out_o   = ctrl.mdr_out;
    assign c_out_o     = ctrl.c_out;
    assign r_out_o     = ctrl.r_out;
    assign mar_en_o    = ctrl.mar_en;
    assign mdr_en_o    = ctrl.mdr_en;
    assign ir_en_o     = ctrl.ir_en;
    assign y_en_o      = ctrl.y_en;
    assign z_en_o      = ctrl.z_en;
    assign pc_en_o     = ctrl.pc_en;
    assign hi_en_o     = ctrl.hi_en;
    assign lo_en_o     = ctrl.lo_en;
    assign con_en_o    = ctrl.con_en;
    assign gra_o       = ctrl.gra;
    assign grb_o       = ctrl.grb;
    assign grc_o       = ctrl.grc;
    assign r_in_o      = ctrl.r_in;
    assign ba_out_o    = ctrl.ba_out;
    assign inc_pc_o    = ctrl.inc_pc;
    assign read_o      = ctrl.read;
    assign write_o     = ctrl.write;
    assign alu_op_o    = ctrl.alu_op;
    assign run_o       = ctrl.run;
    assign fault_o     = ctrl.fault;

endmodule
